// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit: data-memory access engine, splits boundary-crossing accesses
// into two word transfers over a valid/ready port.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    input  logic              mem_write_i,
    input  logic [1:0]        mem_width_i,
    input  logic              mem_sign_extend_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_ready_i,
    input  logic [31:0]       dmem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        off_q;
    logic [1:0]        width_q;
    logic              sign_q;
    logic              we_q;
    logic              cross_q;
    logic [31:0]       lo_q;
    logic [31:0]       wdata_hi_q;
    logic [3:0]        be_hi_q;
    logic [ADDR_W-1:0] addr_hi_q;

    logic [2:0]        nbytes_in;
    logic [3:0]        mask_in;
    logic [1:0]        off_in;
    logic              cross_in;
    logic [3:0]        be_lo_in;
    logic [3:0]        be_hi_in;
    logic [63:0]       wshift_in;
    logic [ADDR_W-1:0] word_addr_in;
    logic [63:0]       merged;
    logic [31:0]       aligned;
    logic [31:0]       load_result;

    // Decode of the incoming request, registered on acceptance.
    always_comb begin
        nbytes_in = 3'd4;
        mask_in   = 4'b1111;
        case (mem_width_i)
            2'b00: begin nbytes_in = 3'd1; mask_in = 4'b0001; end
            2'b01: begin nbytes_in = 3'd2; mask_in = 4'b0011; end
            default: begin nbytes_in = 3'd4; mask_in = 4'b1111; end
        endcase
        off_in       = addr_i[1:0];
        cross_in     = ({1'b0, off_in} + nbytes_in) > 3'd4;
        be_lo_in     = mask_in << off_in;
        be_hi_in     = mask_in >> (3'd4 - {1'b0, off_in});
        wshift_in    = {32'b0, wdata_i} << {off_in, 3'b000};
        word_addr_in = {addr_i[ADDR_W-1:2], 2'b00};
    end

    // Load alignment: the word just returned is the high half when in SECOND.
    always_comb begin
        merged      = (state == SECOND) ? {dmem_rdata_i, lo_q} : {32'b0, dmem_rdata_i};
        aligned     = merged[{off_q, 3'b000} +: 32];
        load_result = aligned;
        case (width_q)
            2'b00:   load_result = {{24{sign_q & aligned[7]}}, aligned[7:0]};
            2'b01:   load_result = {{16{sign_q & aligned[15]}}, aligned[15:0]};
            default: load_result = aligned;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            off_q        <= 2'b00;
            width_q      <= 2'b00;
            sign_q       <= 1'b0;
            we_q         <= 1'b0;
            cross_q      <= 1'b0;
            lo_q         <= 32'b0;
            wdata_hi_q   <= 32'b0;
            be_hi_q      <= 4'b0;
            addr_hi_q    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            rdata_o      <= 32'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 4'b0;
            dmem_wdata_o <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    if (req_valid_i) begin
                        state        <= FIRST;
                        off_q        <= off_in;
                        width_q      <= mem_width_i;
                        sign_q       <= mem_sign_extend_i;
                        we_q         <= mem_write_i;
                        cross_q      <= cross_in;
                        wdata_hi_q   <= wshift_in[63:32];
                        be_hi_q      <= be_hi_in;
                        addr_hi_q    <= word_addr_in + ADDR_W'(4);
                        busy_o       <= 1'b1;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_write_i;
                        dmem_addr_o  <= word_addr_in;
                        dmem_be_o    <= be_lo_in;
                        dmem_wdata_o <= wshift_in[31:0];
                    end
                end
                FIRST: begin
                    if (dmem_ready_i) begin
                        lo_q <= dmem_rdata_i;
                        if (cross_q) begin
                            state        <= SECOND;
                            dmem_addr_o  <= addr_hi_q;
                            dmem_be_o    <= be_hi_q;
                            dmem_wdata_o <= wdata_hi_q;
                        end else begin
                            state      <= DONE;
                            dmem_req_o <= 1'b0;
                            dmem_we_o  <= 1'b0;
                            done_o     <= 1'b1;
                            if (!we_q) rdata_o <= load_result;
                        end
                    end
                end
                SECOND: begin
                    if (dmem_ready_i) begin
                        state      <= DONE;
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        done_o     <= 1'b1;
                        if (!we_q) rdata_o <= load_result;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit: directed self-checking bench for load_store_unit.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        mem_write;
    logic [1:0]  mem_width;
    logic        mem_sign_extend;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int          vectors = 0;
    int          miscompares = 0;
    int          wait_cycles = 0;
    int          wcnt = 0;
    logic [31:0] word100 = 32'h0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } xfer_t;
    xfer_t log_q[$];

    load_store_unit #(.ADDR_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid),
        .mem_write_i(mem_write), .mem_width_i(mem_width),
        .mem_sign_extend_i(mem_sign_extend), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .rdata_o(rdata),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_ready_i(dmem_ready), .dmem_rdata_i(dmem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: ready after wait_cycles of pending request, high when idle.
    assign dmem_ready = (wcnt >= wait_cycles);
    always_comb begin
        case (dmem_addr)
            32'h0000_0100: dmem_rdata = word100;
            32'h0000_01FC: dmem_rdata = 32'hAA00_0000;
            32'h0000_0200: dmem_rdata = 32'h0000_00BB;
            default:       dmem_rdata = 32'h5A5A_5A5A;
        endcase
    end
    always @(posedge clk) begin
        if (dmem_req && !dmem_ready) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        if (dmem_req && dmem_ready)
            log_q.push_back('{we: dmem_we, addr: dmem_addr, be: dmem_be, wdata: dmem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic we, input logic [1:0] w, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd, input logic junk,
                         output int lat, output logic [31:0] rd);
        logic [31:0] s_addr;
        logic [3:0]  s_be;
        logic [31:0] s_wd;
        s_addr = 0; s_be = 0; s_wd = 0;
        log_q.delete();
        @(negedge clk);
        req_valid = 1'b1; mem_write = we; mem_width = w; mem_sign_extend = sgn;
        addr = a; wdata = wd;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req_valid = junk && (lat == 2 || lat == 3);
            if (req_valid) begin
                addr = 32'h0000_03FC; mem_write = ~we; wdata = 32'h0; mem_width = 2'b00;
            end
            if (junk && lat == 1) begin
                s_addr = dmem_addr; s_be = dmem_be; s_wd = dmem_wdata;
            end
            if (junk && lat == 3) begin
                check("wait_addr_stable", dmem_addr, s_addr);
                check("wait_be_stable", dmem_be, s_be);
                check("wait_wdata_stable", dmem_wdata, s_wd);
                check("wait_busy_req", {busy, dmem_req}, 2'b11);
            end
        end while (!done && lat < 60);
        if (lat >= 60) check("done_timeout", done, 1'b1);
        rd = rdata;
        @(negedge clk);
        check("done_one_cycle", {done, busy}, 2'b00);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        rst_n = 1'b0; req_valid = 0; mem_write = 0; mem_width = 0;
        mem_sign_extend = 0; addr = 0; wdata = 0;
        #2;
        check("reset_ctrl", {busy, done, dmem_req, dmem_we}, 4'b0000);
        check("reset_data", {dmem_addr, rdata}, 64'h0);
        check("reset_be_wdata", {dmem_be, dmem_wdata}, 36'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Aligned word store
        do_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, lat, rd);
        check("st_word_lat", lat, 2);
        check("st_word_n", log_q.size(), 1);
        check("st_word_xfer", log_q[0], {1'b1, 32'h100, 4'b1111, 32'hDEADBEEF});

        // Byte loads with/without sign extension
        word100 = 32'h80FF_FFFF;
        do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, lat, rd);
        check("ldb_s_lat", lat, 2);
        check("ldb_s_be", log_q[0].be, 4'b1000);
        check("ldb_s_rdata", rd, 32'hFFFF_FF80);
        do_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0, lat, rd);
        check("ldb_u_rdata", rd, 32'h0000_0080);

        // Half load crossing a word boundary
        do_op(1'b0, 2'b01, 1'b0, 32'h1FF, 32'h0, 1'b0, lat, rd);
        check("ldh_x_lat", lat, 3);
        check("ldh_x_n", log_q.size(), 2);
        check("ldh_x_xfer0", {log_q[0].addr, log_q[0].be}, {32'h1FC, 4'b1000});
        check("ldh_x_xfer1", {log_q[1].addr, log_q[1].be}, {32'h200, 4'b0001});
        check("ldh_x_rdata", rd, 32'h0000_BBAA);

        // Word store crossing; load result must survive the store
        do_op(1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344, 1'b0, lat, rd);
        check("st_x_lat", lat, 3);
        check("st_x_xfer0", log_q[0], {1'b1, 32'h100, 4'b1100, 32'h33440000});
        check("st_x_xfer1", log_q[1], {1'b1, 32'h104, 4'b0011, 32'h00001122});
        check("st_rdata_held", rdata, 32'h0000_BBAA);

        // Width 11 behaves as an unextended word
        do_op(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, 1'b0, lat, rd);
        check("ld_w11_rdata", rd, 32'h80FF_FFFF);

        // Half load wrapping past the top of the address space
        do_op(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, lat, rd);
        check("wrap_xfer1_addr", {log_q[1].addr, log_q[1].be}, {32'h0, 4'b0001});
        check("wrap_rdata", rd, 32'h0000_5A5A);

        // Wait states with spurious requests while busy
        wait_cycles = 3;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, lat, rd);
        wait_cycles = 0;
        check("wait_lat", lat, 5);
        check("wait_n", log_q.size(), 1);
        check("wait_rdata", rd, 32'h80FF_FFFF);
        check("wait_no_extra_req", {busy, dmem_req}, 2'b00);

        // Asynchronous reset while in SECOND
        log_q.delete();
        @(negedge clk);
        req_valid = 1'b1; mem_write = 1'b0; mem_width = 2'b01; mem_sign_extend = 1'b0;
        addr = 32'h1FF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 wait_cycles = 10;
        @(negedge clk);
        check("rst_in_second", {dmem_req, dmem_addr}, {1'b1, 32'h200});
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {busy, done, dmem_req, dmem_we}, 4'b0000);
        check("rst_mid_data", {dmem_addr, rdata}, 64'h0);
        check("rst_mid_be_wdata", {dmem_be, dmem_wdata}, 36'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles = 0;
        repeat (3) @(negedge clk);
        check("rst_no_second_half", log_q.size(), 1);
        check("rst_idle", {busy, dmem_req}, 2'b00);

        // Normal operation after reset
        do_op(1'b0, 2'b01, 1'b1, 32'h1FE, 32'h0, 1'b0, lat, rd);
        check("post_rst_lat", lat, 2);
        check("post_rst_be", log_q[0].be, 4'b1100);
        check("post_rst_rdata", rd, 32'hFFFF_AA00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the data-memory side of the decoded control fields `mem_write`, `mem_width` and `mem_sign_extend`.
- Takes one load/store request from the MEM stage and drives a word-addressed memory port with a valid/ready handshake.
- Splits accesses that cross a word boundary into two word transfers.
- Returns load data aligned and extended, and holds `busy_o` so the pipeline stalls until completion.

Parameters:
- ADDR_W, 32, byte-address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  MEM stage presents an access; sampled only in IDLE.
- mem_write_i  in  1  1 = store, 0 = load.
- mem_width_i  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- mem_sign_extend_i  in  1  load sign-extend enable (ignored for stores and word loads).
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, least-significant bytes used.
- busy_o  out  1  access in progress; pipeline must stall.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load result; valid when done_o is high and held until the next done_o.
- dmem_req_o  out  1  memory transfer request.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] always 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  write data, lane-aligned.
- dmem_ready_i  in  1  memory accepts or completes the transfer this cycle.
- dmem_rdata_i  in  32  read word, valid in the cycle dmem_ready_i is high for a read.

Behaviour:
- Reset (async, rst_n_i low):
  - State goes to IDLE.
  - busy_o, done_o, dmem_req_o, dmem_we_o are 0.
  - dmem_addr_o, dmem_be_o, dmem_wdata_o, rdata_o are 0.
  - Reset mid-transfer abandons the access; no second half is issued.
- States: IDLE, FIRST, SECOND, DONE.
- IDLE:
  - On req_valid_i, register addr/width/sign/we/wdata and go to FIRST.
  - busy_o rises in the next cycle.
  - req_valid_i is ignored in every other state.
- Field derivation:
  - nbytes = 1 / 2 / 4 from width.
  - mask = 0001 / 0011 / 1111.
  - off = addr[1:0].
  - cross = (off + nbytes > 4).
- FIRST:
  - dmem_addr_o = {addr[ADDR_W-1:2], 00}.
  - dmem_be_o = (mask << off)[3:0].
  - Store data: form W = {32'b0, wdata} << 8*off as 64 bits; dmem_wdata_o = W[31:0].
  - dmem_req_o = 1. All dmem_* outputs are registered and stay stable until dmem_ready_i.
  - On dmem_req_o && dmem_ready_i: for a load, capture dmem_rdata_i as LO. Then go to SECOND if cross, else DONE.
- SECOND:
  - dmem_addr_o = first word address + 4 (wraps modulo 2^ADDR_W).
  - dmem_be_o = mask >> (4 - off).
  - dmem_wdata_o = W[63:32].
  - On ready: for a load, capture HI, then go to DONE.
- DONE:
  - Output for exactly one cycle: done_o = 1, busy_o = 1, dmem_req_o = 0.
  - For loads, rdata_o = extend(({HI, LO} >> 8*off)[8*nbytes-1:0]), where HI = 0 if not cross.
  - Extension: sign-extend if sign=1 and nbytes < 4, else zero-extend.
  - For stores, rdata_o is unchanged.
  - Next cycle: IDLE, busy_o = 0.
- dmem_ready_i while dmem_req_o = 0 is ignored.
- A ready in the same cycle req is first raised counts; there is no minimum wait.
- Latency with zero-wait memory:
  - Aligned: req accepted at cycle 0, transfer at cycle 1, done_o at cycle 2.
  - Crossing: done_o at cycle 3.
  - Each wait cycle on ready adds one.
- Back-to-back: a new req_valid_i is accepted in the cycle after DONE (IDLE). Minimum spacing is 3 cycles.

Test Plan:
- Aligned word store: addr=0x100, wdata=0xDEADBEEF, width=10, ready tied 1 -> one transfer, addr 0x100, be=1111, wdata 0xDEADBEEF; done_o at cycle 2.
- Byte load with sign extension: addr=0x103, width=00, sign=1, rdata word 0x80FFFFFF -> be=1000, rdata_o=0xFFFFFF80. Repeat with sign=0 -> 0x00000080.
- Misaligned half load crossing a word: addr=0x1FF, width=01, sign=0; mem word 0x1FC=0xAA000000, word 0x200=0x000000BB -> two reads with be 1000 then 0001; rdata_o=0x0000BBAA; done_o at cycle 3.
- Misaligned word store crossing: addr=0x102, wdata=0x11223344 -> first access addr 0x100, be=1100, wdata=0x33440000; second access addr 0x104, be=0011, wdata=0x00001122.
- Wait states: ready held low for 3 cycles -> dmem_addr_o, dmem_be_o and dmem_wdata_o stay stable, busy_o stays 1, req_valid_i pulses during busy are ignored; done_o at cycle 5.
- Reset mid-op: assert rst_n_i=0 during SECOND -> all outputs go to 0 immediately, state IDLE; after release the next request runs normally.
